// File: rtl/rom_burst.sv
// Fixed-content ROM with a burst reader: one start request streams len+1 consecutive words.
// Optional macro ROM_PARITY_EN adds a registered parity output for the read data register.
module rom_burst #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic              OE,
  output logic [DATA_W-1:0] out,
  output logic              valid,
  output logic              busy,
  output logic              done
`ifdef ROM_PARITY_EN
  ,
  output logic              parity
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_rem;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_done;
  logic              w_accept;

  // Words past the initialised image read as zero; each word is resized to DATA_W.
  function automatic logic [DATA_W-1:0] romWord(input logic [ADDR_W-1:0] a);
    logic [31:0] w;
    case (int'(a))
      0:       w = 32'h15350076;
      1:       w = 32'h5952599F;
      2:       w = 32'h3F800000;
      3:       w = 32'h3E800000;
      4:       w = 32'h40400000;
      5:       w = 32'h41200000;
      6:       w = 32'h3EA00000;
      7:       w = 32'h3F600000;
      default: w = 32'h0;
    endcase
    return DATA_W'(w);
  endfunction

  // A start arriving in the done-pulse cycle is dropped, so only a quiet IDLE accepts.
  assign w_accept = (r_state == IDLE) && start && !r_done;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_rem   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_valid <= (r_state == READ);
      r_done  <= (r_state == DONE);
      if (w_accept) begin
        r_ptr <= base_addr;
        r_rem <= len;
      end else if (r_state == READ) begin
        r_data <= romWord(r_ptr);
        r_ptr  <= (int'(r_ptr) == DEPTH - 1) ? '0 : r_ptr + 1'b1;
        if (r_rem != '0) begin
          r_rem <= r_rem - 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = READ;
      READ:    if (r_rem == '0) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    busy  = (r_state != IDLE);
    valid = r_valid;
    done  = r_done;
  end

  assign out = OE ? r_data : {DATA_W{1'bz}};

`ifdef ROM_PARITY_EN
  logic r_parity;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if (!w_accept && (r_state == READ)) begin
      r_parity <= ^romWord(r_ptr);
    end
  end

  assign parity = r_parity;
`endif

endmodule

// File: tb/tb_rom_burst.sv
// Randomised bench for rom_burst: bursts are predicted from the ROM image with modular
// address arithmetic, while start noise and OE toggling are thrown at the block.
module tb_rom_burst;

  logic        clock;
  logic        reset;
  logic        start;
  logic [2:0]  base_addr;
  logic [2:0]  len;
  logic        OE;
  logic [31:0] out;
  logic        valid;
  logic        busy;
  logic        done;
`ifdef ROM_PARITY_EN
  logic        parity;
`endif

  int checkCount;
  int failCount;
  logic [31:0] lastWord;
  logic [31:0] romImg [8] = '{32'h15350076, 32'h5952599F, 32'h3F800000, 32'h3E800000,
                              32'h40400000, 32'h41200000, 32'h3EA00000, 32'h3F600000};

  rom_burst #(.ADDR_W(3), .DATA_W(32)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
    .OE(OE), .out(out), .valid(valid), .busy(busy), .done(done)
`ifdef ROM_PARITY_EN
    , .parity(parity)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input int b, input int l);
    start     = s;
    base_addr = 3'(b);
    len       = 3'(l);
  endtask

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  // A two-state simulator resolves an undriven bus to zero; every ROM word is nonzero.
  task automatic checkData(input logic [31:0] exp);
    logic zLike;
    if (OE) begin
      checkOutput("out", out, exp);
    end else begin
      zLike = (out === {32{1'bz}}) || (out === 32'h0);
      checkOutput("outZ", {31'h0, zLike}, 32'h1);
    end
  endtask

  task automatic checkFlags(input string tag, input logic v, input logic b, input logic d);
    checkOutput({tag, "_valid"}, {31'h0, valid}, {31'h0, v});
    checkOutput({tag, "_busy"},  {31'h0, busy},  {31'h0, b});
    checkOutput({tag, "_done"},  {31'h0, done},  {31'h0, d});
  endtask

  task automatic runBurst(input int base, input int ln, input bit disturb);
    logic [31:0] exp;
    OE = 1'b1;
    applyStimulus(1'b1, base, ln);
    stepCycle();
    applyStimulus(1'b0, $urandom, $urandom);
    checkFlags("accept", 1'b0, 1'b1, 1'b0);
    for (int k = 0; k <= ln; k++) begin
      if (disturb) begin
        applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom);
        OE = 1'($urandom_range(0, 1));
      end
      stepCycle();
      exp = romImg[(base + k) % 8];
      checkFlags("word", 1'b1, 1'b1, 1'b0);
      checkData(exp);
`ifdef ROM_PARITY_EN
      checkOutput("parity", {31'h0, parity}, {31'h0, ^exp});
`endif
      lastWord = exp;
    end
    OE = 1'b1;
    if (disturb) applyStimulus(1'b1, $urandom, $urandom);
    else applyStimulus(1'b0, 0, 0);
    stepCycle();
    checkFlags("donePulse", 1'b0, 1'b0, 1'b1);
    checkData(lastWord);
    stepCycle();
    checkFlags("afterDone", 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 0);
    stepCycle();
    checkFlags("idle", 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    lastWord   = 32'h0;
    reset      = 1'b1;
    OE         = 1'b1;
    applyStimulus(1'b1, 3, 2);
    stepCycle();
    stepCycle();
    checkFlags("reset", 1'b0, 1'b0, 1'b0);
    checkData(32'h0);
`ifdef ROM_PARITY_EN
    checkOutput("resetParity", {31'h0, parity}, 32'h0);
`endif
    OE = 1'b0;
    #1;
    checkData(32'h0);
    OE = 1'b1;
    applyStimulus(1'b0, 0, 0);
    reset = 1'b0;
    stepCycle();
    checkFlags("idleAfterReset", 1'b0, 1'b0, 1'b0);
    checkData(32'h0);

    runBurst(2, 3, 1'b0);
    runBurst(6, 3, 1'b0);
    runBurst(1, 5, 1'b1);
    runBurst(0, 0, 1'b0);

    // Reset lands while the second word of a full-depth burst is on the output.
    applyStimulus(1'b1, 0, 7);
    stepCycle();
    applyStimulus(1'b0, 0, 0);
    stepCycle();
    checkData(romImg[0]);
    stepCycle();
    checkData(romImg[1]);
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    checkFlags("midReset", 1'b0, 1'b0, 1'b0);
    checkData(32'h0);
    stepCycle();
    checkFlags("postReset", 1'b0, 1'b0, 1'b0);
    stepCycle();
    checkFlags("noDone", 1'b0, 1'b0, 1'b0);
    lastWord = 32'h0;

    for (int n = 0; n < 12; n++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        OE = 1'($urandom_range(0, 1));
        stepCycle();
        checkFlags("gap", 1'b0, 1'b0, 1'b0);
        checkData(lastWord);
      end
      runBurst($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
